// File: rtl/decoder_scan_seq_if.sv
// Bus between a sweep controller and decoder_scan_seq.
// The slave modport belongs to the sequencer and the master modport to whoever drives it.
// The optional pause wire exists only when DECODER_SCAN_SEQ_PAUSE_EN is defined.
interface decoder_scan_seq_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               oneshot;
  logic [3:0]         ch_mask;
  logic [DWELL_W-1:0] dwell;
`ifdef DECODER_SCAN_SEQ_PAUSE_EN
  logic               pause;
`endif
  logic               s1;
  logic               s0;
  logic               sel_valid;
  logic               busy;
  logic               wrap;
  logic               done;

  modport master (
`ifdef DECODER_SCAN_SEQ_PAUSE_EN
    output pause,
`endif
    output start, stop, oneshot, ch_mask, dwell,
    input  s1, s0, sel_valid, busy, wrap, done
  );

  modport slave (
`ifdef DECODER_SCAN_SEQ_PAUSE_EN
    input  pause,
`endif
    input  start, stop, oneshot, ch_mask, dwell,
    output s1, s0, sel_valid, busy, wrap, done
  );
endinterface

// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: drives the s1/s0 select inputs of a 2x4 decoder.
// It sweeps the enabled channels in ascending order and holds each channel for dwell+1 cycles.
// It supports continuous or one-shot sweeps, abort, and wrap/done pulses.
// Optional feature: define DECODER_SCAN_SEQ_PAUSE_EN to add a pause input that
// freezes the sweep while it is in SCAN.
//
// state   | meaning
// IDLE    | no sweep; select 00, sel_valid low
// SCAN    | holding r_ch for the remaining r_cnt+1 cycles
module decoder_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  decoder_scan_seq_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t             r_state;
  logic [1:0]         r_ch;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_oneshot;
  logic               r_wrap;
  logic               r_done;

  state_t             w_state;
  logic [1:0]         w_ch;
  logic [DWELL_W-1:0] w_cnt;
  logic               w_oneshot;
  logic               w_wrap;
  logic               w_done;
  logic               w_pause;
  logic [1:0]         w_first;
  logic [1:0]         w_next;

`ifdef DECODER_SCAN_SEQ_PAUSE_EN
  assign w_pause = bus.pause;
`else
  assign w_pause = 1'b0;
`endif

  // Lowest enabled channel, used when a sweep starts.
  function automatic logic [1:0] lowest_ch(input logic [3:0] mask);
    lowest_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) lowest_ch = 2'(i);
    end
  endfunction

  // Next enabled channel after ch, searching upward modulo 4.
  // The last candidate is ch itself, which covers the single-channel case.
  function automatic logic [1:0] after_ch(input logic [1:0] ch, input logic [3:0] mask);
    logic [1:0] idx;
    after_ch = ch;
    for (int k = 4; k >= 1; k--) begin
      idx = ch + 2'(k);
      if (mask[idx]) after_ch = idx;
    end
  endfunction

  assign w_first = lowest_ch(bus.ch_mask);
  assign w_next  = after_ch(r_ch, bus.ch_mask);

  // State and datapath registers; reset aborts any sweep with no pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ch      <= 2'd0;
      r_cnt     <= '0;
      r_oneshot <= 1'b0;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ch      <= w_ch;
      r_cnt     <= w_cnt;
      r_oneshot <= w_oneshot;
      r_wrap    <= w_wrap;
      r_done    <= w_done;
    end
  end

  // Next-state logic: stop beats pause, and pause beats an advance.
  always_comb begin
    w_state   = r_state;
    w_ch      = r_ch;
    w_cnt     = r_cnt;
    w_oneshot = r_oneshot;
    w_wrap    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ch  = 2'd0;
        w_cnt = '0;
        if (bus.start && !bus.stop && (bus.ch_mask != 4'd0)) begin
          w_state   = ST_SCAN;
          w_ch      = w_first;
          w_cnt     = bus.dwell;
          w_oneshot = bus.oneshot;
        end
      end
      ST_SCAN: begin
        if (bus.stop) begin
          w_state = ST_IDLE;
          w_ch    = 2'd0;
          w_cnt   = '0;
        end else if (w_pause) begin
          w_cnt = r_cnt;
        end else if (r_cnt != '0) begin
          w_cnt = r_cnt - DWELL_W'(1);
        end else if (bus.ch_mask == 4'd0) begin
          w_state = ST_IDLE;
          w_ch    = 2'd0;
          w_done  = 1'b1;
        end else if (w_next <= r_ch) begin
          if (r_oneshot) begin
            w_state = ST_IDLE;
            w_ch    = 2'd0;
            w_done  = 1'b1;
          end else begin
            w_ch   = w_next;
            w_cnt  = bus.dwell;
            w_wrap = 1'b1;
          end
        end else begin
          w_ch  = w_next;
          w_cnt = bus.dwell;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_ch    = 2'd0;
        w_cnt   = '0;
      end
    endcase
  end

  // Output decode from registers only; r_ch is forced to 0 whenever the sequencer is in IDLE.
  always_comb begin
    bus.s1        = r_ch[1];
    bus.s0        = r_ch[0];
    bus.sel_valid = (r_state == ST_SCAN);
    bus.busy      = (r_state == ST_SCAN);
    bus.wrap      = r_wrap;
    bus.done      = r_done;
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Testbench for decoder_scan_seq. It applies a table of per-cycle vectors, each with
// hand-computed outputs expected after the sampling edge, and then runs a mid-sweep reset sequence.
module tb_decoder_scan_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  decoder_scan_seq_if #(.DWELL_W(8)) bus ();

  decoder_scan_seq #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic       osh;
    logic [3:0] mask;
    logic [7:0] dwell;
    logic       pause;
    logic [5:0] exp;   // {s1,s0,sel_valid,busy,wrap,done}
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic st, input logic sp, input logic os, input logic [3:0] m,
                   input logic [7:0] d, input logic pa, input logic [1:0] s,
                   input logic sv, input logic bz, input logic wr, input logic dn);
    vec_t t;
    t.start = st; t.stop = sp; t.osh = os; t.mask = m; t.dwell = d; t.pause = pa;
    t.exp   = {s, sv, bz, wr, dn};
    vecs.push_back(t);
  endtask

  function automatic logic [5:0] outs();
    return {bus.s1, bus.s0, bus.sel_valid, bus.busy, bus.wrap, bus.done};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic os,
                       input logic [3:0] m, input logic [7:0] d, input logic pa);
    bus.start   = st;
    bus.stop    = sp;
    bus.oneshot = os;
    bus.ch_mask = m;
    bus.dwell   = d;
`ifdef DECODER_SCAN_SEQ_PAUSE_EN
    bus.pause   = pa;
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // One-shot sweep over all channels, dwell 2: select 0..3 for 3 cycles each, then done.
    v(1,0,1,4'hF,8'd2,0, 2'd0,1,1,0,0);
    for (int i = 1; i < 12; i++) v(0,0,1,4'hF,8'd2,0, 2'(i/3),1,1,0,0);
    v(0,0,1,4'hF,8'd2,0, 2'd0,0,0,0,1);
    v(0,0,1,4'hF,8'd2,0, 2'd0,0,0,0,0);

    // Continuous sweep over mask 1010, dwell 0: 01,11,01,11 with wrap on each return to 01.
    v(1,0,0,4'hA,8'd0,0, 2'd1,1,1,0,0);
    v(0,0,0,4'hA,8'd0,0, 2'd3,1,1,0,0);
    v(0,0,0,4'hA,8'd0,0, 2'd1,1,1,1,0);
    v(0,0,0,4'hA,8'd0,0, 2'd3,1,1,0,0);
    v(0,0,0,4'hA,8'd0,0, 2'd1,1,1,1,0);
    v(0,1,0,4'hA,8'd0,0, 2'd0,0,0,0,0);
    v(0,0,0,4'hA,8'd0,0, 2'd0,0,0,0,0);

    // Stop arriving on the same cycle that ch 01 reaches counter==0.
    v(1,0,0,4'hF,8'd1,0, 2'd0,1,1,0,0);
    v(0,0,0,4'hF,8'd1,0, 2'd0,1,1,0,0);
    v(0,0,0,4'hF,8'd1,0, 2'd1,1,1,0,0);
    v(0,0,0,4'hF,8'd1,0, 2'd1,1,1,0,0);
    v(0,1,0,4'hF,8'd1,0, 2'd0,0,0,0,0);
    v(0,0,0,4'hF,8'd1,0, 2'd0,0,0,0,0);

    // Start with an empty mask is ignored; start together with stop in IDLE is ignored.
    v(1,0,0,4'h0,8'd3,0, 2'd0,0,0,0,0);
    v(1,1,0,4'hF,8'd3,0, 2'd0,0,0,0,0);

    // One-shot over mask 0011, dwell 1, with start held high while busy (no restart).
    v(1,0,1,4'h3,8'd1,0, 2'd0,1,1,0,0);
    v(1,0,1,4'h3,8'd1,0, 2'd0,1,1,0,0);
    v(1,0,1,4'h3,8'd1,0, 2'd1,1,1,0,0);
    v(1,0,1,4'h3,8'd1,0, 2'd1,1,1,0,0);
    v(0,0,1,4'h3,8'd1,0, 2'd0,0,0,0,1);
    v(0,0,1,4'h3,8'd1,0, 2'd0,0,0,0,0);

    // Single channel 2, continuous: wrap every 2 cycles, and a mask of 0 at the advance ends with done.
    v(1,0,0,4'h4,8'd1,0, 2'd2,1,1,0,0);
    v(0,0,0,4'h4,8'd1,0, 2'd2,1,1,0,0);
    v(0,0,0,4'h4,8'd1,0, 2'd2,1,1,1,0);
    v(0,0,0,4'h4,8'd1,0, 2'd2,1,1,0,0);
    v(0,0,0,4'h4,8'd1,0, 2'd2,1,1,1,0);
    v(0,0,0,4'h0,8'd7,0, 2'd2,1,1,0,0);
    v(0,0,0,4'h0,8'd7,0, 2'd0,0,0,0,1);
    v(0,0,0,4'h0,8'd7,0, 2'd0,0,0,0,0);

`ifdef DECODER_SCAN_SEQ_PAUSE_EN
    // Dwell 3 with a 5-cycle pause on ch 10: ch 10 is held for 9 cycles.
    v(1,0,1,4'hF,8'd3,0, 2'd0,1,1,0,0);
    for (int i = 2; i <= 8; i++) v(0,0,1,4'hF,8'd3,0, 2'((i-1)/4),1,1,0,0);
    v(0,0,1,4'hF,8'd3,0, 2'd2,1,1,0,0);
    for (int i = 0; i < 5; i++) v(0,0,1,4'hF,8'd3,1, 2'd2,1,1,0,0);
    for (int i = 0; i < 3; i++) v(0,0,1,4'hF,8'd3,0, 2'd2,1,1,0,0);
    for (int i = 0; i < 4; i++) v(0,0,1,4'hF,8'd3,0, 2'd3,1,1,0,0);
    v(0,0,1,4'hF,8'd3,0, 2'd0,0,0,0,1);
    // Pause while IDLE has no effect, and stop overrides pause.
    v(1,0,0,4'h2,8'd2,1, 2'd1,1,1,0,0);
    v(0,1,0,4'h2,8'd2,1, 2'd0,0,0,0,0);
`endif

    drive(0,0,0,4'h0,8'd0,0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", outs(), 6'b000000);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].osh, vecs[i].mask, vecs[i].dwell, vecs[i].pause);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Reset in the middle of a continuous sweep clears the outputs immediately.
    drive(1,0,0,4'hF,8'd2,0);
    @(posedge clk);
    #1;
    drive(0,0,0,4'hF,8'd2,0);
    repeat (4) @(posedge clk);
    #1;
    check("midsweep_before_reset", outs(), 6'b011100);
    #1;
    rst_n = 1'b0;
    #1;
    check("midsweep_async_reset", outs(), 6'b000000);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("held_in_reset", outs(), 6'b000000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("idle_after_midsweep_reset", outs(), 6'b000000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
